// File: rtl/a_coef_buffer_pkg.sv
// Shared constants, FSM state encodings and the element-to-storage mapping
// for the A-matrix coefficient buffer.
package a_coef_buffer_pkg;

  localparam int unsigned ROWS      = 8;
  localparam int unsigned COLS      = 4;
  localparam int unsigned COEF_W    = 7;
  localparam int unsigned NUM_WORDS = ROWS * COLS / 2;
  localparam int unsigned WORD_W    = 2 * COEF_W;
  localparam int unsigned ADDR_W    = $clog2(NUM_WORDS);
  localparam int unsigned ROW_W     = $clog2(ROWS);
  localparam int unsigned COL_W     = $clog2(COLS);

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY  = 2'd0;
  localparam state_t ST_LOADED = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  // Element (r,c) lives in word c*4 + r/2.
  function automatic logic [ADDR_W-1:0] coef_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return {c, r[ROW_W-1:1]};
  endfunction

  // Even rows occupy the upper half of the packed word, odd rows the lower.
  function automatic logic [COEF_W-1:0] coef_sel(input logic [WORD_W-1:0] w,
                                                 input logic             odd);
    return odd ? w[COEF_W-1:0] : w[WORD_W-1:COEF_W];
  endfunction

endpackage

// File: rtl/a_coef_buffer_index_gen.sv
// Row/column beat index counter for the coefficient stream.
// Order: column-major by default; row-major when A_BUF_ROW_MAJOR_EN is defined.
module a_coef_index_gen
  import a_coef_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             adv,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] nxt_row,
  output logic [COL_W-1:0] nxt_col,
  output logic             last
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             row_wrap, col_wrap;

  assign row_wrap = (row_q == ROW_W'(ROWS - 1));
  assign col_wrap = (col_q == COL_W'(COLS - 1));

  always_comb begin
`ifdef A_BUF_ROW_MAJOR_EN
    nxt_col = col_wrap ? '0 : col_q + COL_W'(1);
    nxt_row = col_wrap ? row_q + ROW_W'(1) : row_q;
`else
    nxt_row = row_wrap ? '0 : row_q + ROW_W'(1);
    nxt_col = row_wrap ? col_q + COL_W'(1) : col_q;
`endif
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (init) begin
      row_d = '0;
      col_d = '0;
    end else if (adv) begin
      row_d = nxt_row;
      col_d = nxt_col;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = row_wrap && col_wrap;

endmodule

// File: rtl/a_coef_buffer.sv
// Captures the packed A-matrix words from the ROM loader and replays them as a
// valid/ready coefficient stream. Stream order option: A_BUF_ROW_MAJOR_EN.
module a_coef_buffer
  import a_coef_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WORD_W-1:0] w_data,
  input  logic              aload_done,
  input  logic              clear,
  input  logic              start,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [COEF_W-1:0] coef_data,
  output logic [ROW_W-1:0]  coef_row,
  output logic [COL_W-1:0]  coef_col,
  output logic              coef_last,
  output logic              loaded,
  output logic              busy,
  output logic              stream_done
);

  logic [WORD_W-1:0]    mem_q [NUM_WORDS];
  logic [NUM_WORDS-1:0] mask_q, mask_d;
  state_t               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [COEF_W-1:0]    data_q, data_d;

  logic                 wr_en, accept, idx_init, idx_adv, idx_last;
  logic [ROW_W-1:0]     idx_row, nxt_row;
  logic [COL_W-1:0]     idx_col, nxt_col;

  a_coef_index_gen u_index_gen (
    .clk     (clk),
    .rst     (rst),
    .init    (idx_init),
    .adv     (idx_adv),
    .row     (idx_row),
    .col     (idx_col),
    .nxt_row (nxt_row),
    .nxt_col (nxt_col),
    .last    (idx_last)
  );

  assign wr_en  = we && !clear && (state_q != ST_STREAM);
  assign accept = valid_q && coef_ready;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    valid_d  = valid_q;
    data_d   = data_q;
    idx_init = 1'b0;
    idx_adv  = 1'b0;
    if (clear) begin
      state_d  = ST_EMPTY;
      mask_d   = '0;
      valid_d  = 1'b0;
      data_d   = '0;
      idx_init = 1'b1;
    end else begin
      if (wr_en) mask_d[w_addr] = 1'b1;
      case (state_q)
        ST_EMPTY: begin
          if ((&mask_d) && aload_done) state_d = ST_LOADED;
        end
        ST_LOADED: begin
          if (start) begin
            state_d  = ST_STREAM;
            valid_d  = 1'b1;
            data_d   = coef_sel(mem_q[coef_addr('0, '0)], 1'b0);
            idx_init = 1'b1;
          end
        end
        ST_STREAM: begin
          // The output register is refilled from the next index in the same
          // cycle the current beat is accepted, so beats run back-to-back.
          if (accept) begin
            if (idx_last) begin
              state_d  = ST_FINISH;
              valid_d  = 1'b0;
              data_d   = '0;
              idx_init = 1'b1;
            end else begin
              idx_adv = 1'b1;
              data_d  = coef_sel(mem_q[coef_addr(nxt_row, nxt_col)], nxt_row[0]);
            end
          end
        end
        ST_FINISH: state_d = ST_LOADED;
        default:   state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[w_addr] <= w_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      mask_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign coef_valid  = valid_q;
  assign coef_data   = data_q;
  assign coef_row    = idx_row;
  assign coef_col    = idx_col;
  assign coef_last   = valid_q && idx_last;
  assign loaded      = (state_q != ST_EMPTY);
  assign busy        = (state_q == ST_STREAM);
  assign stream_done = (state_q == ST_FINISH);

endmodule

// File: tb/tb_a_coef_buffer.sv
// Scoreboard bench for a_coef_buffer: expected beats are queued at start and
// popped as the consumer accepts them.
module tb_a_coef_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  w_addr;
  logic [13:0] w_data;
  logic        aload_done;
  logic        clear;
  logic        start;
  logic        coef_valid;
  logic        coef_ready;
  logic [6:0]  coef_data;
  logic [2:0]  coef_row;
  logic [1:0]  coef_col;
  logic        coef_last;
  logic        loaded;
  logic        busy;
  logic        stream_done;

  always #5 clk = ~clk;

  a_coef_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .aload_done  (aload_done),
    .clear       (clear),
    .start       (start),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .coef_data   (coef_data),
    .coef_row    (coef_row),
    .coef_col    (coef_col),
    .coef_last   (coef_last),
    .loaded      (loaded),
    .busy        (busy),
    .stream_done (stream_done)
  );

  typedef struct packed {
    logic [6:0] data;
    logic [2:0] row;
    logic [1:0] col;
    logic       last;
  } beat_t;

  beat_t       exp_q[$];
  logic [13:0] model_mem [16];
  int          checks = 0;
  int          errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream();
    int unsigned r, c;
    beat_t b;
    for (int unsigned i = 0; i < 32; i++) begin
`ifdef A_BUF_ROW_MAJOR_EN
      r = i / 4;
      c = i % 4;
`else
      r = i % 8;
      c = i / 8;
`endif
      b.row  = 3'(r);
      b.col  = 2'(c);
      b.last = (i == 31);
      b.data = (r % 2 == 0) ? model_mem[c*4 + r/2][13:7] : model_mem[c*4 + r/2][6:0];
      exp_q.push_back(b);
    end
  endtask

  task automatic write_word(input int unsigned a, input logic done);
    we         = 1'b1;
    w_addr     = 4'(a);
    w_data     = {7'(2*a), 7'(2*a + 1)};
    aload_done = done;
    model_mem[a] = {7'(2*a), 7'(2*a + 1)};
    step();
    we = 1'b0;
  endtask

  task automatic run_stream(input int ready_mode, input int we_at, input int clear_at);
    beat_t cur, prev, exp_b;
    logic  prev_stall, rdy, aborted, saw_done;
    int    n_acc, cyc;
    prev_stall = 1'b0;
    aborted    = 1'b0;
    n_acc      = 0;
    cyc        = 0;
    prev       = '0;
    push_stream();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (coef_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: valid=%b busy=%b, required 1 1", coef_valid, busy);
    end
    while (exp_q.size() > 0 && cyc < 400) begin
      cur = {coef_data, coef_row, coef_col, coef_last};
      if (prev_stall) begin
        checks++;
        if (cur !== prev || coef_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: got %h valid=%b, required %h valid=1", cur, coef_valid, prev);
        end
      end
      if (clear_at >= 0 && n_acc == clear_at) begin
        aborted = 1'b1;
        break;
      end
      rdy = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      coef_ready = rdy;
      we     = (n_acc == we_at);
      w_addr = 4'd0;
      w_data = 14'h3FFF;
      if (coef_valid !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL valid_gap: valid=%b with %0d beats outstanding, required 1", coef_valid, exp_q.size());
      end else if (rdy) begin
        exp_b = exp_q.pop_front();
        checks++;
        if (cur !== exp_b) begin
          errors++;
          $display("FAIL beat%0d: got data=%0d r=%0d c=%0d last=%b, required data=%0d r=%0d c=%0d last=%b",
                   n_acc, cur.data, cur.row, cur.col, cur.last, exp_b.data, exp_b.row, exp_b.col, exp_b.last);
        end
        n_acc++;
      end
      prev       = cur;
      prev_stall = coef_valid && !rdy;
      step();
      cyc++;
    end
    we = 1'b0;
    if (aborted) begin
      clear      = 1'b1;
      coef_ready = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if (coef_valid !== 1'b0 || loaded !== 1'b0 || busy !== 1'b0 || stream_done !== 1'b0) begin
        errors++;
        $display("FAIL clear_abort: valid=%b loaded=%b busy=%b done=%b, required 0 0 0 0",
                 coef_valid, loaded, busy, stream_done);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (stream_done || coef_valid) saw_done = 1'b1;
        step();
      end
      checks++;
      if (saw_done !== 1'b0) begin
        errors++;
        $display("FAIL clear_no_done: done/valid seen=%b, required 0", saw_done);
      end
      exp_q.delete();
      return;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: %0d beats missing, required 0", exp_q.size());
      exp_q.delete();
      return;
    end
    if (ready_mode == 0) begin
      checks++;
      if (cyc != 32) begin
        errors++;
        $display("FAIL throughput: %0d cycles for 32 beats, required 32", cyc);
      end
    end
    checks++;
    if (stream_done !== 1'b1 || coef_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL finish: done=%b valid=%b busy=%b, required 1 0 0", stream_done, coef_valid, busy);
    end
    step();
    checks++;
    if (stream_done !== 1'b0 || loaded !== 1'b1 || busy !== 1'b0 || coef_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_finish: done=%b loaded=%b busy=%b valid=%b, required 0 1 0 0",
               stream_done, loaded, busy, coef_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; we = 1'b0; w_addr = '0; w_data = '0; aload_done = 1'b0;
    clear = 1'b0; start = 1'b0; coef_ready = 1'b0;
    step();
    step();
    checks++;
    if ({coef_valid, coef_data, coef_row, coef_col, coef_last, loaded, busy, stream_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%0d r=%0d c=%0d last=%b loaded=%b busy=%b done=%b, required all 0",
               coef_valid, coef_data, coef_row, coef_col, coef_last, loaded, busy, stream_done);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_load_stream();
    for (int unsigned a = 0; a < 15; a++) write_word(a, 1'b0);
    checks++;
    if (loaded !== 1'b0) begin
      errors++;
      $display("FAIL loaded_early: loaded=%b, required 0", loaded);
    end
    write_word(15, 1'b1);
    checks++;
    if (loaded !== 1'b1) begin
      errors++;
      $display("FAIL loaded_rise: loaded=%b, required 1", loaded);
    end
    run_stream(0, -1, -1);
  endtask

  task automatic test_backpressure();
    run_stream(1, -1, -1);
  endtask

  task automatic test_write_dropped();
    run_stream(0, 5, -1);
    run_stream(0, -1, -1);
  endtask

  task automatic test_clear_mid();
    run_stream(0, -1, 10);
  endtask

  task automatic test_incomplete();
    for (int unsigned a = 0; a < 16; a++) begin
      if (a != 9) write_word(a, 1'b1);
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (loaded !== 1'b0 || coef_valid !== 1'b0) begin
        errors++;
        $display("FAIL incomplete: loaded=%b valid=%b, required 0 0", loaded, coef_valid);
      end
    end
    start = 1'b0;
    write_word(9, 1'b1);
    checks++;
    if (loaded !== 1'b1) begin
      errors++;
      $display("FAIL late_word: loaded=%b, required 1", loaded);
    end
  endtask

  task automatic test_async_reset();
    coef_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({coef_valid, coef_data, coef_row, coef_col, coef_last, loaded, busy, stream_done} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%0d r=%0d c=%0d last=%b loaded=%b busy=%b done=%b, required all 0",
               coef_valid, coef_data, coef_row, coef_col, coef_last, loaded, busy, stream_done);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if (loaded !== 1'b0 || coef_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: loaded=%b valid=%b, required 0 0", loaded, coef_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load_stream();
    test_backpressure();
    test_write_dropped();
    test_clear_mid();
    test_incomplete();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
